delta_dram_arbiter: RTL and testbench
=====================================

# delta_dram_arbiter

Shares the single accelerator DRAM port among the Delta loaders and extractors: input loader, output extractor, bias loader and weight manager. Replaces static port multiplexing by the top controller with a round-robin burst arbiter, so loaders can overlap phases. Each requester asks for a burst of word accesses. The arbiter generates per-beat addresses, drives the DRAM handshake and returns per-beat strobes and read data to the granted requester.

## Interface
- NUM_REQ, 4, number of requesters; index 0=input, 1=output, 2=bias, 3=weight.
- LEN_W, 8, burst-length field width.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  burst request, level, per requester.
- req_write  in  NUM_REQ  1=write burst, 0=read burst.
- req_addr  in  32 x NUM_REQ  byte base address of the burst.
- req_len  in  LEN_W x NUM_REQ  beats in the burst; 0 is treated as 1.
- req_wdata  in  32 x NUM_REQ  write data for the current beat.
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
- beat_valid  out  NUM_REQ  one-cycle pulse when a beat completes (read data valid / write accepted).
- rdata  out  32  read data; valid only with beat_valid.
- burst_done  out  NUM_REQ  one-cycle pulse after the last beat.
- busy  out  1  high in every state except IDLE.
- DRAM_Read, DRAM_Write  out  1  access strobes.
- DRAM_Address  out  32  beat address.
- DRAM_WriteData  out  32  write data.
- DRAM_ReadData  in  32  read data.
- DRAM_DataReady  in  1  read-beat acknowledge.
- DRAM_WriteDone  in  1  write-beat acknowledge.

## Operation
- FSM states: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - If any req is high, the round-robin picker selects the first asserted index at or after rr_ptr, wrapping.
  - Latch idx, base address, length (0→1), write flag and beat=0. Go to ISSUE with gnt[idx]=1.
  - If no req is high, stay in IDLE.
- ISSUE:
  - DRAM_Read=!write, DRAM_Write=write.
  - DRAM_Address = base + (beat<<2), modulo 2^32.
  - DRAM_WriteData = req_wdata[idx].
  - Hold until the matching acknowledge: DataReady for reads, WriteDone for writes. The other acknowledge is ignored.
  - On the matching acknowledge: beat_valid[idx]=1 that cycle, rdata=DRAM_ReadData (combinational pass-through).
  - If beat==len-1, go to DONE. Otherwise beat++ and go to GAP.
- GAP: strobes low for one cycle, then back to ISSUE. This gives the DRAM a fresh request edge.
- DONE: burst_done[idx]=1, gnt cleared, rr_ptr=(idx+1) mod NUM_REQ, go to IDLE.
- req is sampled only in IDLE. Dropping req mid-burst does not abort the burst.
- Requesters advance req_wdata on their own beat_valid.
- Acknowledges arriving in IDLE, GAP or DONE are ignored.
- Reset (asynchronous, any state):
  - state=IDLE, rr_ptr=0, beat=0.
  - gnt, beat_valid, burst_done, busy, DRAM_Read, DRAM_Write all 0.
  - DRAM_Address, DRAM_WriteData and rdata are 0.
  - An in-flight burst is discarded.

## Timing
- Request high in IDLE at cycle t: gnt and strobe high from t+1 (registered state).
- Acknowledge at cycle a, not the last beat: next strobe at a+2.
- Last-beat acknowledge at cycle a: burst_done at a+1, IDLE at a+2, next grant at the earliest a+3.
- Zero-wait DRAM throughput is one beat per 2 cycles. Per-burst overhead is 2 cycles (DONE, IDLE).
- Fairness: a continuously requesting index waits at most NUM_REQ-1 bursts.

## Structure
- Package delta_arb_pkg holds:
  - the state enum;
  - NUM_REQ and LEN_W defaults;
  - requester index constants REQ_INPUT/REQ_OUTPUT/REQ_BIAS/REQ_WEIGHT.
- Sub-module delta_rr_picker: combinational. Inputs req and rr_ptr; outputs a one-hot pick and its index.
- Burst counter, latch registers and the FSM live in delta_dram_arbiter.

## Test plan
- Single read: req[2], addr=0x100, len=3, DataReady one cycle after each strobe → addresses 0x100/0x104/0x108; three beat_valid[2] pulses carrying the driven data; burst_done[2] once.
- Contention: req=4'b1111 from reset, all len=1 → grant order 0,1,2,3,0; no two gnt bits ever high together.
- Write burst: req[1], write, len=2, WriteDone after 3 wait cycles, DataReady pulsed meanwhile → DataReady ignored; DRAM_WriteData follows req_wdata; 2 beats.
- len=0 and address wrap: addr=0xFFFFFFFC, len=2 → second address 0x00000000; len=0 yields exactly one beat.
- Reset mid-burst: reset low during ISSUE beat 1 → all outputs 0 immediately; after release with req[3] high, grant goes to index 3 and restarts at beat 0.
- Requester drops req after its grant → burst still completes all len beats.

Source files
------------

// File: rtl/delta_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : delta_arb_pkg
//  Description : Shared types and constants for the Delta DRAM port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package delta_arb_pkg;

    // Default sizing of the arbiter
    localparam int NUM_REQ_DEFAULT = 4;
    localparam int LEN_W_DEFAULT   = 8;

    // Requester slot assignment on the shared DRAM port
    localparam int REQ_INPUT  = 0;
    localparam int REQ_OUTPUT = 1;
    localparam int REQ_BIAS   = 2;
    localparam int REQ_WEIGHT = 3;

    // Burst sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/delta_rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : delta_rr_picker
//  Description : Combinational round-robin picker. Selects the first asserted
//                request at or after the pointer, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module delta_rr_picker
    import delta_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_pick_idx,
    output logic               o_valid
);

    int w_cand;

    // Scan from the pointer position; the first hit wins
    always_comb begin
        o_pick     = '0;
        o_pick_idx = '0;
        o_valid    = 1'b0;
        w_cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(i_rr_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid        = 1'b1;
                o_pick[w_cand] = 1'b1;
                o_pick_idx     = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/delta_dram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : delta_dram_arbiter
//  Description : Round-robin burst arbiter sharing the accelerator DRAM port
//                between the input/output/bias/weight movers. Generates beat
//                addresses, drives the DRAM handshake and routes strobes and
//                read data back to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module delta_dram_arbiter
    import delta_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int LEN_W   = LEN_W_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0][31:0]      req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0][31:0]      req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            beat_valid,
    output logic [31:0]                   rdata,
    output logic [NUM_REQ-1:0]            burst_done,
    output logic                          busy,
    output logic                          DRAM_Read,
    output logic                          DRAM_Write,
    output logic [31:0]                   DRAM_Address,
    output logic [31:0]                   DRAM_WriteData,
    input  logic [31:0]                   DRAM_ReadData,
    input  logic                          DRAM_DataReady,
    input  logic                          DRAM_WriteDone
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_REQ-1:0]  r_onehot;
    logic [31:0]         r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;
    logic                r_write;

    logic [NUM_REQ-1:0]  w_pick;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_valid;
    logic                w_issue;
    logic                w_ack;
    logic                w_last;

    delta_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    // Only the acknowledge matching the burst direction counts, and only in ISSUE
    assign w_issue = (r_state == ST_ISSUE);
    assign w_ack   = w_issue && (r_write ? DRAM_WriteDone : DRAM_DataReady);
    assign w_last  = (r_beat == (r_len - LEN_W'(1)));

    // Burst sequencer: grant latch, beat counter and round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_base   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_write  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_idx    <= w_pick_idx;
                        r_onehot <= w_pick;
                        r_base   <= req_addr[w_pick_idx];
                        // A zero length still moves one word
                        r_len    <= (req_len[w_pick_idx] == '0) ? LEN_W'(1) : req_len[w_pick_idx];
                        r_write  <= req_write[w_pick_idx];
                        r_beat   <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_beat  <= r_beat + LEN_W'(1);
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_state <= ST_ISSUE;
                end
                default: begin
                    r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Requester-side and DRAM-side outputs decoded from the registered state
    always_comb begin
        gnt            = (w_issue || (r_state == ST_GAP)) ? r_onehot : '0;
        beat_valid     = w_ack ? r_onehot : '0;
        burst_done     = (r_state == ST_DONE) ? r_onehot : '0;
        busy           = (r_state != ST_IDLE);
        DRAM_Read      = w_issue && !r_write;
        DRAM_Write     = w_issue && r_write;
        DRAM_Address   = w_issue ? (r_base + 32'({r_beat, 2'b00})) : '0;
        DRAM_WriteData = w_issue ? req_wdata[r_idx] : '0;
        rdata          = (w_ack && !r_write) ? DRAM_ReadData : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_delta_dram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_delta_dram_arbiter
//  Description : Directed self-checking bench for delta_dram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delta_dram_arbiter;
    import delta_arb_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0]       req_write = '0;
    logic [3:0][31:0] req_addr = '0;
    logic [3:0][7:0]  req_len = '0;
    logic [3:0][31:0] req_wdata = '0;
    logic [3:0]       gnt, beat_valid, burst_done;
    logic [31:0]      rdata, DRAM_Address, DRAM_WriteData;
    logic             busy, DRAM_Read, DRAM_Write;
    logic [31:0]      DRAM_ReadData = '0;
    logic             DRAM_DataReady = 1'b0;
    logic             DRAM_WriteDone = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    delta_dram_arbiter #(.NUM_REQ(4), .LEN_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .beat_valid     (beat_valid),
        .rdata          (rdata),
        .burst_done     (burst_done),
        .busy           (busy),
        .DRAM_Read      (DRAM_Read),
        .DRAM_Write     (DRAM_Write),
        .DRAM_Address   (DRAM_Address),
        .DRAM_WriteData (DRAM_WriteData),
        .DRAM_ReadData  (DRAM_ReadData),
        .DRAM_DataReady (DRAM_DataReady),
        .DRAM_WriteDone (DRAM_WriteDone)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant must never name two requesters at once
    always @(negedge clock) begin
        if (reset) chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        int n = 0;
        while (gnt == 4'b0 && n < 16) begin
            tick();
            n++;
        end
        #1 chk(tag, gnt, exp);
    endtask

    // Entered in the first cycle of an ISSUE beat; leaves in the following
    // ISSUE cycle (not last) or in the IDLE cycle after DONE (last).
    task automatic do_beat(input string tag, input int idx, input bit wr, input logic [31:0] addr,
                           input int waits, input logic [31:0] data, input bit last);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        #1;
        chk({tag, "_strobe"}, {DRAM_Read, DRAM_Write}, wr ? 2'b01 : 2'b10);
        chk({tag, "_addr"}, DRAM_Address, addr);
        chk({tag, "_gnt"}, gnt, oh);
        if (wr) chk({tag, "_wdata"}, DRAM_WriteData, data);
        for (int w = 0; w < waits; w++) begin
            tick();
            if (wr) DRAM_DataReady = 1'b1; else DRAM_WriteDone = 1'b1;
            #1 chk({tag, "_ignored_ack"}, beat_valid, 4'b0);
        end
        tick();
        DRAM_DataReady = !wr;
        DRAM_WriteDone = wr;
        DRAM_ReadData  = data;
        #1 chk({tag, "_beat_valid"}, beat_valid, oh);
        if (wr) chk({tag, "_wdata_ack"}, DRAM_WriteData, data);
        else    chk({tag, "_rdata"}, rdata, data);
        tick();
        DRAM_DataReady = 1'b0;
        DRAM_WriteDone = 1'b0;
        #1 chk({tag, "_gap_strobe"}, {DRAM_Read, DRAM_Write}, 2'b00);
        chk({tag, "_burst_done"}, burst_done, last ? oh : 4'b0);
        tick();
        if (last) begin
            #1 chk({tag, "_idle_busy"}, busy, 1'b0);
            chk({tag, "_idle_done"}, burst_done, 4'b0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        #1 chk("rst_gnt", gnt, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", {DRAM_Read, DRAM_Write}, 2'b00);
        chk("rst_addr", DRAM_Address, 32'h0);
        chk("rst_wdata", DRAM_WriteData, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", burst_done, 4'b0);
        tick();
        reset = 1'b1;

        // Single 3-beat read on the bias slot; request dropped after grant
        req_addr[REQ_BIAS] = 32'h0000_0100;
        req_len[REQ_BIAS]  = 8'd3;
        req[REQ_BIAS]      = 1'b1;
        wait_gnt("rd_gnt", 4'b0100);
        req[REQ_BIAS] = 1'b0;
        do_beat("rd0", REQ_BIAS, 1'b0, 32'h0000_0100, 0, 32'hA0A0_0000, 1'b0);
        do_beat("rd1", REQ_BIAS, 1'b0, 32'h0000_0104, 0, 32'hB1B1_0001, 1'b0);
        do_beat("rd2", REQ_BIAS, 1'b0, 32'h0000_0108, 0, 32'hC2C2_0002, 1'b1);

        // Two-beat write on the output slot with slow WriteDone
        req_addr[REQ_OUTPUT]  = 32'h0000_2000;
        req_len[REQ_OUTPUT]   = 8'd2;
        req_write[REQ_OUTPUT] = 1'b1;
        req_wdata[REQ_OUTPUT] = 32'h1111_1111;
        req[REQ_OUTPUT]       = 1'b1;
        wait_gnt("wr_gnt", 4'b0010);
        req[REQ_OUTPUT] = 1'b0;
        do_beat("wr0", REQ_OUTPUT, 1'b1, 32'h0000_2000, 3, 32'h1111_1111, 1'b0);
        req_wdata[REQ_OUTPUT] = 32'h2222_2222;
        do_beat("wr1", REQ_OUTPUT, 1'b1, 32'h0000_2004, 3, 32'h2222_2222, 1'b1);
        req_write[REQ_OUTPUT] = 1'b0;

        // Address wrap past 2^32
        req_addr[REQ_INPUT] = 32'hFFFF_FFFC;
        req_len[REQ_INPUT]  = 8'd2;
        req[REQ_INPUT]      = 1'b1;
        wait_gnt("wrap_gnt", 4'b0001);
        req[REQ_INPUT] = 1'b0;
        do_beat("wrap0", REQ_INPUT, 1'b0, 32'hFFFF_FFFC, 0, 32'h0000_5A5A, 1'b0);
        do_beat("wrap1", REQ_INPUT, 1'b0, 32'h0000_0000, 0, 32'h0000_A5A5, 1'b1);

        // Zero length behaves as a single beat
        req_addr[REQ_WEIGHT] = 32'h0000_0040;
        req_len[REQ_WEIGHT]  = 8'd0;
        req[REQ_WEIGHT]      = 1'b1;
        wait_gnt("len0_gnt", 4'b1000);
        req[REQ_WEIGHT] = 1'b0;
        do_beat("len0", REQ_WEIGHT, 1'b0, 32'h0000_0040, 0, 32'h0BAD_F00D, 1'b1);

        // Full contention from reset: order 0,1,2,3,0
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 32'h1000 * i;
            req_len[i]  = 8'd1;
        end
        req = 4'b1111;
        reset = 1'b1;
        wait_gnt("rr_gnt0", 4'b0001);
        do_beat("rr0", 0, 1'b0, 32'h0000_0000, 0, 32'h0000_C000, 1'b1);
        wait_gnt("rr_gnt1", 4'b0010);
        do_beat("rr1", 1, 1'b0, 32'h0000_1000, 0, 32'h0000_C001, 1'b1);
        wait_gnt("rr_gnt2", 4'b0100);
        do_beat("rr2", 2, 1'b0, 32'h0000_2000, 0, 32'h0000_C002, 1'b1);
        wait_gnt("rr_gnt3", 4'b1000);
        do_beat("rr3", 3, 1'b0, 32'h0000_3000, 0, 32'h0000_C003, 1'b1);
        wait_gnt("rr_gnt4", 4'b0001);
        do_beat("rr4", 0, 1'b0, 32'h0000_0000, 0, 32'h0000_C004, 1'b1);

        // Reset in the middle of beat 1 of a 4-beat read
        req                 = 4'b0001;
        req_addr[REQ_INPUT] = 32'h0000_0300;
        req_len[REQ_INPUT]  = 8'd4;
        wait_gnt("mid_gnt", 4'b0001);
        req = 4'b0000;
        do_beat("mid0", REQ_INPUT, 1'b0, 32'h0000_0300, 0, 32'h0000_3300, 1'b0);
        #1 chk("mid_addr1", DRAM_Address, 32'h0000_0304);
        reset = 1'b0;
        #1 chk("mid_rst_gnt", gnt, 4'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_strobe", {DRAM_Read, DRAM_Write}, 2'b00);
        chk("mid_rst_addr", DRAM_Address, 32'h0);
        chk("mid_rst_bv", beat_valid, 4'b0);
        req_addr[REQ_WEIGHT] = 32'h0000_0400;
        req_len[REQ_WEIGHT]  = 8'd2;
        req = 4'b1000;
        tick();
        tick();
        reset = 1'b1;
        wait_gnt("post_gnt", 4'b1000);
        req = 4'b0000;
        do_beat("post0", REQ_WEIGHT, 1'b0, 32'h0000_0400, 0, 32'h0000_4400, 1'b0);
        do_beat("post1", REQ_WEIGHT, 1'b0, 32'h0000_0404, 0, 32'h0000_4404, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
